exe_div_seq: RTL and testbench

Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU in the execute stage. It runs a radix-2 restoring divide over WIDTH iterations and holds the execute stage via stall_o while it works. On completion it presents the result for one cycle, alongside the ALU result path, so the instruction can retire.

---
 rtl/exe_div_seq.sv | 181 ++++++++++++++++++
 tb/tb_exe_div_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_div_seq.sv
// Purpose : execute-stage sequencer for RV32M DIV/DIVU/REM/REMU using a radix-2 restoring divide.
// Latency : normal op accepted in cycle T gives done_o in T+WIDTH+2; divide-by-zero and signed overflow give done_o in T+1.
// Backpr. : stall_o holds the execute stage from the accept cycle through FIX; new starts are ignored while busy.
// Ports   : clk_i/rst_ni      clock, async active-low reset
//           start_i/funct3_i  divide-class request and op select (4=DIV,5=DIVU,6=REM,7=REMU)
//           dat_a_i/dat_b_i   dividend (rs1) / divisor (rs2)
//           kill_i            flush of the execute stage
//           stall_o/busy_o    hold upstream / sequencer not idle
//           done_o/result_o   one-cycle completion pulse / quotient or remainder
module exe_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] dat_a_i,
  input  logic [WIDTH-1:0] dat_b_i,
  input  logic             kill_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             sel_rem_q, sel_rem_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Request decode
  logic             accept;
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             div_zero, sgn_ovf;

  assign accept    = (state_q == S_IDLE) && start_i && funct3_i[2] && !kill_i;
  assign is_signed = ~funct3_i[0];
  assign a_neg     = is_signed & dat_a_i[WIDTH-1];
  assign b_neg     = is_signed & dat_b_i[WIDTH-1];
  assign a_abs     = a_neg ? (~dat_a_i + ONE) : dat_a_i;
  assign b_abs     = b_neg ? (~dat_b_i + ONE) : dat_b_i;
  assign div_zero  = (dat_b_i == '0);
  // Only signed ops can overflow: MIN / -1 has no representable quotient.
  assign sgn_ovf   = is_signed && (dat_a_i == MIN_NEG) && (dat_b_i == ONES);

  // One restoring iteration. The shifted partial remainder is WIDTH+1 bits;
  // when it is >= divisor the difference always fits in WIDTH bits, so the
  // low-order subtraction alone is exact.
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;

  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - dvs_q;

  // Sign fix-up of the unsigned magnitudes
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign quo_fix = qneg_q ? (~quo_q + ONE) : quo_q;
  assign rem_fix = rneg_q ? (~rem_q + ONE) : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_rem_d = funct3_i[1];
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          dvs_d     = b_abs;
          quo_d     = a_abs;
          rem_d     = '0;
          cnt_d     = '0;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = funct3_i[1] ? dat_a_i : ONES;
          end else if (sgn_ovf) begin
            state_d  = S_DONE;
            result_d = funct3_i[1] ? '0 : MIN_NEG;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (kill_i) begin
          // Flushed instruction: keep the previously published result.
          state_d = S_IDLE;
        end else begin
          result_d = sel_rem_q ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        // Done is still signalled under kill; the next stage drops it.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      sel_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      sel_rem_q <= sel_rem_d;
      result_q  <= result_d;
    end
  end

  // Stall covers the accept cycle so the instruction stays put until DONE.
  assign stall_o  = accept || (state_q == S_CALC) || (state_q == S_FIX);
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_exe_div_seq.sv
// Testbench for exe_div_seq: directed and random divide ops with a result scoreboard.
module tb_exe_div_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] dat_a_i = '0;
  logic [31:0] dat_b_i = '0;
  logic        kill_i = 1'b0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  exe_div_seq #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .dat_a_i  (dat_a_i),
    .dat_b_i  (dat_b_i),
    .kill_i   (kill_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done result=%08h required=no done", result_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (result_o !== e) begin
          errors++;
          $display("FAIL result got=%08h required=%08h", result_o, e);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
      return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  // Issue one op and follow it to completion, checking stall, latency and idle-at-issue.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input bit poke, input string name);
    int t0;
    int stall_cnt;
    bit seen;
    exp_q.push_back(exp_res);
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_issue got=%b required=0", name, busy_o);
    end
    start_i = 1'b1; funct3_i = f3; dat_a_i = a; dat_b_i = b;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_at_accept got=%b required=1", name, stall_o);
    end
    t0 = cyc;
    @(negedge clk_i);
    // Scramble operands after the accept edge; the DUT must use latched values.
    dat_a_i = $urandom; dat_b_i = $urandom;
    seen = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      start_i  = poke && (cyc - t0 == 5);
      funct3_i = start_i ? 3'b101 : 3'b000;
      #1;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) stall_cnt++;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout got=no done required=done after %0d cycles", name, exp_lat);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      if (cyc - t0 != exp_lat) begin
        errors++;
        $display("FAIL %s latency got=%0d required=%0d", name, cyc - t0, exp_lat);
      end
      checks++;
      if (stall_cnt != exp_lat - 1) begin
        errors++;
        $display("FAIL %s stall_cycles got=%0d required=%0d", name, stall_cnt, exp_lat - 1);
      end
      checks++;
      if (stall_o !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_at_done got=%b required=0", name, stall_o);
      end
    end
    last_exp = exp_res;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if ({stall_o, busy_o, done_o, result_o} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b_%08h required=000_00000000", stall_o, busy_o, done_o, result_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_unsigned();
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0, "divu_100_7");
    run_op(3'b111, 32'd100, 32'd7, 32'd2,  34, 1'b0, "remu_100_7");
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 1'b0, "divu_big");
    run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0, "remu_big");
  endtask

  task automatic test_signed();
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, "rem_m7_2");
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0, "div_7_m2");
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0, "rem_7_m2");
  endtask

  task automatic test_special();
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "div_by_zero");
    run_op(3'b111, 32'd5, 32'd0, 32'd5, 1, 1'b0, "remu_by_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, "rem_ovf");
  endtask

  task automatic test_kill(input int kill_at);
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b101; dat_a_i = 32'd1000; dat_b_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0; funct3_i = 3'b000;
    repeat (kill_at - 1) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_at_%0d idle got busy=%b stall=%b required busy=0 stall=0", kill_at, busy_o, stall_o);
    end
    checks++;
    if (result_o !== last_exp) begin
      errors++;
      $display("FAIL kill_at_%0d result_kept got=%08h required=%08h", kill_at, result_o, last_exp);
    end
    repeat (30) @(negedge clk_i);
    run_op(3'b101, 32'd9, 32'd3, 32'd3, 34, 1'b0, "divu_after_kill");
  endtask

  task automatic test_ignored_starts();
    // Non-divide funct3: no stall, no activity.
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b000; dat_a_i = 32'd6; dat_b_i = 32'd3;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_stall got=%b required=0", stall_o);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy got=%b required=0", busy_o);
    end
    // Start together with kill: rejected.
    start_i = 1'b1; funct3_i = 3'b101; kill_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL start_kill_stall got=%b required=0", stall_o);
    end
    @(negedge clk_i);
    start_i = 1'b0; kill_i = 1'b0; funct3_i = 3'b000;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_kill_busy got=%b required=0", busy_o);
    end
    // Start while busy: the second request must not disturb the first.
    run_op(3'b111, 32'd1234567, 32'd1000, 32'd567, 34, 1'b1, "start_while_busy");
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b100; dat_a_i = 32'd77; dat_b_i = 32'd5;
    @(negedge clk_i);
    start_i = 1'b0; funct3_i = 3'b000;
    repeat (4) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({stall_o, busy_o, done_o, result_o} !== 35'h0) begin
      errors++;
      $display("FAIL reset_mid_calc got=%b%b%b_%08h required=000_00000000", stall_o, busy_o, done_o, result_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_exp = '0;
    repeat (40) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_busy got=%b required=0", busy_o);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          lat;
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 4) b = 32'h0;
      lat = (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
      run_op(f3, a, b, model(f3, a, b), lat, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill(10);
    test_kill(33);
    test_ignored_starts();
    test_back_to_back_random();
    test_reset_mid_calc();
    repeat (3) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
